// File: rtl/wired_iq_issue_sel_pkg.sv
// Shared types for the issue-select stage: operand word and default sizing.
package wired_iq_issue_sel_pkg;
  localparam int WORD_W       = 32;
  localparam int IQ_DEPTH_DEF = 4;
  localparam int RREG_CNT_DEF = 2;
  localparam int PAYLOAD_DEF  = 32;

  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/wired_iq_age_matrix.sv
// Age matrix over issue-queue entries; yields the one-hot oldest candidate.
module wired_iq_age_matrix
  import wired_iq_issue_sel_pkg::*;
#(
  parameter int IQ_DEPTH = IQ_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IQ_DEPTH-1:0] alloc_i,
  input  logic [IQ_DEPTH-1:0] cand_i,
  output logic [IQ_DEPTH-1:0] oldest_o
);
  // r_age[i][j] = 1 means entry i is older than entry j.
  typedef logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0] iq_age_t;

  iq_age_t             r_age;
  logic [IQ_DEPTH-1:0] w_older;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_age <= '0;
    end else begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        for (int j = 0; j < IQ_DEPTH; j++) begin
          if (alloc_i[i])      r_age[i][j] <= 1'b0;
          else if (alloc_i[j]) r_age[i][j] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_older = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      for (int j = 0; j < IQ_DEPTH; j++) begin
        if (j != i && cand_i[j] && r_age[j][i]) w_older[i] = 1'b1;
      end
    end
  end

  assign oldest_o = cand_i & ~w_older;
endmodule

// File: rtl/wired_iq_issue_sel.sv
// Issue select: picks the oldest ready entry, pulses its sel line and
// captures its operands/payload into the issue register feeding execute.
module wired_iq_issue_sel
  import wired_iq_issue_sel_pkg::*;
#(
  parameter int IQ_DEPTH     = IQ_DEPTH_DEF,
  parameter int RREG_CNT     = RREG_CNT_DEF,
  parameter int PAYLOAD_SIZE = PAYLOAD_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush_i,
  input  logic [IQ_DEPTH-1:0]                    alloc_i,
  input  logic [IQ_DEPTH-1:0]                    entry_empty_i,
  input  logic [IQ_DEPTH-1:0]                    entry_ready_i,
  input  word_t [IQ_DEPTH-1:0][RREG_CNT-1:0]     entry_data_i,
  input  logic [IQ_DEPTH-1:0][PAYLOAD_SIZE-1:0]  entry_payload_i,
  output logic [IQ_DEPTH-1:0]                    sel_o,
  output logic                                   issue_valid_o,
  input  logic                                   issue_ready_i,
  output word_t [RREG_CNT-1:0]                   issue_data_o,
  output logic [PAYLOAD_SIZE-1:0]                issue_payload_o
);
  // Handshake: an instruction transfers to execute on a cycle where
  // issue_valid_o & issue_ready_i; while valid & ~ready the register holds.

  logic [IQ_DEPTH-1:0]     r_sel_last;
  logic                    r_issue_valid;
  word_t [RREG_CNT-1:0]    r_issue_data;
  logic [PAYLOAD_SIZE-1:0] r_issue_payload;

  logic [IQ_DEPTH-1:0]     w_cand;
  logic [IQ_DEPTH-1:0]     w_pick;
  logic                    w_can_take;
  word_t [RREG_CNT-1:0]    w_mux_data;
  logic [PAYLOAD_SIZE-1:0] w_mux_payload;

  // Entry ready/empty lag one cycle behind a select, so last cycle's pick
  // is masked to avoid issuing it twice.
  assign w_cand = entry_ready_i & ~entry_empty_i & ~r_sel_last & ~alloc_i;

  wired_iq_age_matrix #(.IQ_DEPTH(IQ_DEPTH)) u_age (
    .clk      (clk),
    .rst      (rst),
    .alloc_i  (alloc_i),
    .cand_i   (w_cand),
    .oldest_o (w_pick)
  );

  assign w_can_take = ~r_issue_valid | issue_ready_i;
  assign sel_o      = w_pick & {IQ_DEPTH{w_can_take & ~flush_i & ~rst}};

  always_comb begin
    w_mux_data    = '0;
    w_mux_payload = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (sel_o[i]) begin
        w_mux_data    = w_mux_data | entry_data_i[i];
        w_mux_payload = w_mux_payload | entry_payload_i[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_last      <= '0;
      r_issue_valid   <= 1'b0;
      r_issue_data    <= '0;
      r_issue_payload <= '0;
    end else begin
      r_sel_last <= sel_o;
      if (flush_i) begin
        r_issue_valid <= 1'b0;
      end else if (|sel_o) begin
        r_issue_valid   <= 1'b1;
        r_issue_data    <= w_mux_data;
        r_issue_payload <= w_mux_payload;
      end else if (issue_ready_i) begin
        r_issue_valid <= 1'b0;
      end
    end
  end

  assign issue_valid_o   = r_issue_valid;
  assign issue_data_o    = r_issue_data;
  assign issue_payload_o = r_issue_payload;
endmodule

// File: tb/tb_wired_iq_issue_sel.sv
// Bench for wired_iq_issue_sel: directed vector table, hand sequences for
// stall/flush/reset, and randomized traffic against an allocation-order model.
module tb_wired_iq_issue_sel;
  import wired_iq_issue_sel_pkg::*;

  localparam int D = 4;
  localparam int R = 2;
  localparam int P = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush_i;
  logic [D-1:0]           alloc_i;
  logic [D-1:0]           entry_empty_i;
  logic [D-1:0]           entry_ready_i;
  word_t [D-1:0][R-1:0]   entry_data_i;
  logic [D-1:0][P-1:0]    entry_payload_i;
  logic [D-1:0]           sel_o;
  logic                   issue_valid_o;
  logic                   issue_ready_i;
  word_t [R-1:0]          issue_data_o;
  logic [P-1:0]           issue_payload_o;

  int n_vec  = 0;
  int n_miss = 0;

  wired_iq_issue_sel #(.IQ_DEPTH(D), .RREG_CNT(R), .PAYLOAD_SIZE(P)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .alloc_i         (alloc_i),
    .entry_empty_i   (entry_empty_i),
    .entry_ready_i   (entry_ready_i),
    .entry_data_i    (entry_data_i),
    .entry_payload_i (entry_payload_i),
    .sel_o           (sel_o),
    .issue_valid_o   (issue_valid_o),
    .issue_ready_i   (issue_ready_i),
    .issue_data_o    (issue_data_o),
    .issue_payload_o (issue_payload_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic         rs;
    logic         fl;
    logic [D-1:0] al;
    logic [D-1:0] em;
    logic [D-1:0] rd;
    logic         ir;
    logic [D-1:0] xs;
    logic         xv;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic set_pattern();
    for (int i = 0; i < D; i++) begin
      for (int r = 0; r < R; r++) entry_data_i[i][r] = 32'hA000_0000 + 32'(i * 16 + r);
      entry_payload_i[i] = 32'hC0DE_0000 + 32'(i);
    end
  endtask

  // driver: apply inputs, check sel_o mid-cycle, check valid after the edge
  task automatic step(input string nm, input int idx, input logic rs, input logic fl,
                      input logic [D-1:0] al, input logic [D-1:0] em, input logic [D-1:0] rd,
                      input logic ir, input logic [D-1:0] xs, input logic xv);
    rst = rs; flush_i = fl; alloc_i = al; entry_empty_i = em; entry_ready_i = rd; issue_ready_i = ir;
    @(negedge clk);
    chk({nm, "_sel"}, idx, 64'(sel_o), 64'(xs));
    @(posedge clk);
    #1;
    chk({nm, "_valid"}, idx, 64'(issue_valid_o), 64'(xv));
  endtask

  task automatic chk_issue(input string nm, input int idx, input int e);
    chk({nm, "_d0"}, idx, 64'(issue_data_o[0]), 64'(32'hA000_0000 + 32'(e * 16)));
    chk({nm, "_d1"}, idx, 64'(issue_data_o[1]), 64'(32'hA000_0001 + 32'(e * 16)));
    chk({nm, "_pay"}, idx, 64'(issue_payload_o), 64'(32'hC0DE_0000 + 32'(e)));
  endtask

  // scoreboard / reference model: entries ordered by last allocation, oldest first
  int                  order[$];
  logic [D-1:0]        m_sel_last;
  logic                m_valid;
  logic [R*32-1:0]     exp_q[$];
  logic [P-1:0]        m_pay;

  function automatic bit in_order(input int k);
    foreach (order[n]) if (order[n] == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_alloc(input logic [D-1:0] al);
    for (int k = 0; k < D; k++) begin
      if (al[k]) begin
        for (int n = 0; n < order.size(); n++) begin
          if (order[n] == k) begin
            order.delete(n);
            break;
          end
        end
        order.push_back(k);
      end
    end
  endtask

  initial begin
    logic [D-1:0] x;
    tbl[0]  = '{1'b0, 1'b0, 4'b0001, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'b0010, 4'b1110, 4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 4'b0100, 4'b1100, 4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'b0000, 4'b1000, 4'b0111, 1'b1, 4'b0001, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 4'b0000, 4'b1000, 4'b0111, 1'b1, 4'b0010, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 4'b0000, 4'b1001, 4'b0110, 1'b1, 4'b0100, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 4'b0000, 4'b1011, 4'b0100, 1'b1, 4'b0000, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 4'b1000, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 4'b0001, 4'b0111, 4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'b0000, 4'b0110, 4'b1001, 1'b1, 4'b1000, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 4'b0000, 4'b0110, 4'b1001, 1'b1, 4'b0001, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 4'b0000, 4'b1110, 4'b0001, 1'b1, 4'b0000, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 4'b0100, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 4'b0010, 4'b1001, 4'b0110, 1'b1, 4'b0100, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 4'b0000, 4'b1001, 4'b0110, 1'b1, 4'b0010, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0};

    rst = 1'b1; flush_i = 1'b0; alloc_i = '0; entry_empty_i = '1; entry_ready_i = '0;
    issue_ready_i = 1'b0;
    set_pattern();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", 0, 64'(sel_o), 64'h0);
    chk("rst_valid", 0, 64'(issue_valid_o), 64'h0);
    chk("rst_data", 0, 64'(issue_data_o), 64'h0);
    chk("rst_pay", 0, 64'(issue_payload_o), 64'h0);

    // directed vector table
    for (int v = 0; v < 18; v++) begin
      step("tbl", v, tbl[v].rs, tbl[v].fl, tbl[v].al, tbl[v].em, tbl[v].rd, tbl[v].ir, tbl[v].xs, tbl[v].xv);
      if (v == 3)  chk_issue("tbl_issue", v, 0);
      if (v == 5)  chk_issue("tbl_issue", v, 2);
      if (v == 10) chk_issue("tbl_issue", v, 3);
      if (v == 15) chk_issue("tbl_issue", v, 2);
    end

    // stall with one issued instruction holding its operands
    entry_data_i[1][0] = 32'hDEAD_BEEF;
    entry_data_i[1][1] = 32'h1234_5678;
    step("stall", 0, 1'b0, 1'b0, 4'b0000, 4'b1101, 4'b0010, 1'b0, 4'b0010, 1'b1);
    entry_data_i[1][0] = 32'h0BAD_0BAD;
    entry_data_i[1][1] = 32'h0BAD_0BAD;
    for (int s = 1; s <= 3; s++) begin
      step("stall", s, 1'b0, 1'b0, 4'b0000, (s == 1) ? 4'b1001 : 4'b1011,
           (s == 1) ? 4'b0110 : 4'b0100, 1'b0, 4'b0000, 1'b1);
      chk("stall_d0", s, 64'(issue_data_o[0]), 64'h0000_0000_DEAD_BEEF);
      chk("stall_d1", s, 64'(issue_data_o[1]), 64'h0000_0000_1234_5678);
      chk("stall_pay", s, 64'(issue_payload_o), 64'h0000_0000_C0DE_0001);
    end
    step("stall", 4, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0);
    set_pattern();

    // flush while valid with a candidate present, alloc in the same cycle
    step("flush", 0, 1'b0, 1'b0, 4'b0000, 4'b1011, 4'b0100, 1'b0, 4'b0100, 1'b1);
    chk_issue("flush_issue", 0, 2);
    step("flush", 1, 1'b0, 1'b1, 4'b1000, 4'b1001, 4'b0110, 1'b1, 4'b0000, 1'b0);
    step("flush", 2, 1'b0, 1'b0, 4'b0000, 4'b0101, 4'b1010, 1'b1, 4'b0010, 1'b1);
    chk_issue("flush_issue", 2, 1);
    step("flush", 3, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0);

    // reset mid-stall, then fresh allocation order
    step("rstm", 0, 1'b0, 1'b0, 4'b0000, 4'b0111, 4'b1000, 1'b0, 4'b1000, 1'b1);
    step("rstm", 1, 1'b1, 1'b0, 4'b0000, 4'b0111, 4'b1000, 1'b0, 4'b0000, 1'b0);
    chk("rstm_data", 1, 64'(issue_data_o), 64'h0);
    chk("rstm_pay", 1, 64'(issue_payload_o), 64'h0);
    step("rstm", 2, 1'b0, 1'b0, 4'b0100, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0);
    step("rstm", 3, 1'b0, 1'b0, 4'b0001, 4'b1011, 4'b0000, 1'b1, 4'b0000, 1'b0);
    step("rstm", 4, 1'b0, 1'b0, 4'b0000, 4'b1010, 4'b0101, 1'b1, 4'b0100, 1'b1);
    chk_issue("rstm_issue", 4, 2);

    // randomized traffic against the model
    step("rnd_rst", 0, 1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0);
    rst = 1'b0;
    order.delete();
    m_sel_last = '0;
    m_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      flush_i = ($urandom_range(15) == 0);
      alloc_i = ($urandom_range(1) == 1) ? (4'b0001 << $urandom_range(3)) : 4'b0000;
      for (int i = 0; i < D; i++) begin
        entry_empty_i[i] = in_order(i) ? ($urandom_range(3) == 0) : 1'b1;
        entry_ready_i[i] = 1'($urandom_range(1));
        for (int r = 0; r < R; r++) entry_data_i[i][r] = $urandom;
        entry_payload_i[i] = $urandom;
      end
      issue_ready_i = ($urandom_range(9) < 7);
      x = '0;
      if (!flush_i && (!m_valid || issue_ready_i)) begin
        foreach (order[n]) begin
          if (x == '0 && entry_ready_i[order[n]] && !entry_empty_i[order[n]] &&
              !m_sel_last[order[n]] && !alloc_i[order[n]]) x[order[n]] = 1'b1;
        end
      end
      @(negedge clk);
      chk("rnd_sel", c, 64'(sel_o), 64'(x));
      @(posedge clk);
      if (flush_i) m_valid = 1'b0;
      else if (x != '0) begin
        m_valid = 1'b1;
        for (int k = 0; k < D; k++) begin
          if (x[k]) begin
            exp_q.delete();
            exp_q.push_back({entry_data_i[k][1], entry_data_i[k][0]});
            m_pay = entry_payload_i[k];
          end
        end
      end else if (issue_ready_i) m_valid = 1'b0;
      m_sel_last = x;
      model_alloc(alloc_i);
      #1;
      chk("rnd_valid", c, 64'(issue_valid_o), 64'(m_valid));
      if (m_valid && exp_q.size() > 0) begin
        chk("rnd_d0", c, 64'(issue_data_o[0]), 64'(exp_q[0][31:0]));
        chk("rnd_d1", c, 64'(issue_data_o[1]), 64'(exp_q[0][63:32]));
        chk("rnd_pay", c, 64'(issue_payload_o), 64'(m_pay));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
